// File: rtl/axil_wr_pkg.sv
// ----------------------------------------------------------------------------
// axil_wr_pkg
//   Shared types and constants for the two-requester AXI-Lite write arbiter.
//   - state_t     : write-sequencer states (IDLE -> XFER -> RESP)
//   - BRESP_*     : AXI write-response codes
//   - req_id_t    : requester identifier (0 or 1)
//   - grant_to_id : converts a one-hot two-way grant into a requester ID
// ----------------------------------------------------------------------------
package axil_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] BRESP_OKAY   = 2'd0;
  localparam logic [1:0] BRESP_EXOKAY = 2'd1;
  localparam logic [1:0] BRESP_SLVERR = 2'd2;
  localparam logic [1:0] BRESP_DECERR = 2'd3;

  typedef logic req_id_t;

  function automatic req_id_t grant_to_id(input logic [1:0] grant);
    return req_id_t'(grant[1]);
  endfunction

endpackage

// File: rtl/axil_rr_arb2.sv
// ----------------------------------------------------------------------------
// axil_rr_arb2
//   Two-way round-robin arbiter. A lone request always wins; when both
//   requesters ask at once, the one that was not granted last wins. After
//   reset requester 0 has priority.
//
//   Ports
//     AXI_ACLK    in   clock
//     AXI_ARESET  in   asynchronous active-high reset
//     req[1:0]    in   request vector (bit n = requester n)
//     advance     in   the current grant is being taken this cycle
//     grant[1:0]  out  one-hot grant (combinational from req and history)
// ----------------------------------------------------------------------------
module axil_rr_arb2
  import axil_wr_pkg::*;
(
  input  logic       AXI_ACLK,
  input  logic       AXI_ARESET,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Requester that won the most recent taken grant. Resetting to 1 makes
  // requester 0 the preferred winner of the first contended arbitration.
  req_id_t last_id;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_id == 1'b1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      last_id <= 1'b1;
    end else if (advance && (grant != '0)) begin
      last_id <= grant_to_id(grant);
    end
  end

endmodule

// File: rtl/axil_wr_arbiter.sv
// ----------------------------------------------------------------------------
// axil_wr_arbiter
//   Arbitrates two write requesters onto one AXI-Lite write master port.
//   In IDLE the round-robin winner gets a combinational READY pulse and its
//   payload is registered; XFER drives AW and W together and drops each VALID
//   independently after its handshake; RESP waits for BVALID and returns the
//   response to the owning requester as a registered DONE pulse.
//   A wait counter watches W stalls and raises ERR_TIMEOUT once when the
//   stall length reaches MAXWAIT+1 cycles; the write is not aborted.
//
//   Ports
//     AXI_ACLK, AXI_ARESET            clock, asynchronous active-high reset
//     REQn_VALID / REQn_READY         requester n request / capture pulse
//     REQn_ADDR / _DATA / _STRB       requester n write payload
//     REQn_DONE / REQn_BRESP          completion pulse and its response code
//     AXI_AW*, AXI_W*, AXI_B*         AXI-Lite write master channels
//     ERR_TIMEOUT                     one-cycle pulse on excessive W stall
// ----------------------------------------------------------------------------
module axil_wr_arbiter
  import axil_wr_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 8,
  parameter int unsigned MAXWAIT          = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESET,

  input  logic                          REQ0_VALID,
  output logic                          REQ0_READY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   REQ0_DATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] REQ0_STRB,
  output logic                          REQ0_DONE,
  output logic [1:0]                    REQ0_BRESP,

  input  logic                          REQ1_VALID,
  output logic                          REQ1_READY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   REQ1_DATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] REQ1_STRB,
  output logic                          REQ1_DONE,
  output logic [1:0]                    REQ1_BRESP,

  output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
  output logic                          AXI_AWVALID,
  input  logic                          AXI_AWREADY,

  output logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
  output logic                          AXI_WVALID,
  input  logic                          AXI_WREADY,

  input  logic [1:0]                    AXI_BRESP,
  input  logic                          AXI_BVALID,
  output logic                          AXI_BREADY,

  output logic                          ERR_TIMEOUT
);

  localparam int unsigned STRB_W  = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_MAX = MAXWAIT + 1;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  state_t                      state;
  req_id_t                     owner;
  logic                        aw_valid;
  logic                        w_valid;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_AXI_DATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]           strb_q;
  logic                        done0_q;
  logic                        done1_q;
  logic [1:0]                  bresp_q;
  logic [CNT_W-1:0]            wait_cnt;
  logic                        err_q;

  logic [1:0] grant;
  logic       take;
  logic       aw_hold;
  logic       w_hold;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  axil_rr_arb2 u_arb (
    .AXI_ACLK   (AXI_ACLK),
    .AXI_ARESET (AXI_ARESET),
    .req        ({REQ1_VALID, REQ0_VALID}),
    .advance    (take),
    .grant      (grant)
  );

  // A grant is only taken in IDLE; reset masks READY since the async reset
  // forces IDLE while requesters may still be presenting VALID.
  assign take       = (state == IDLE) && !AXI_ARESET && (grant != '0);
  assign REQ0_READY = take && grant[0];
  assign REQ1_READY = take && grant[1];

  // A VALID stays up next cycle only if it is up now and not accepted.
  assign aw_hold = aw_valid && !AXI_AWREADY;
  assign w_hold  = w_valid  && !AXI_WREADY;

  // --------------------------------------------------------------------------
  // Write sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state    <= IDLE;
      owner    <= 1'b0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      bresp_q  <= BRESP_OKAY;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            owner    <= grant_to_id(grant);
            addr_q   <= grant[1] ? REQ1_ADDR : REQ0_ADDR;
            data_q   <= grant[1] ? REQ1_DATA : REQ0_DATA;
            strb_q   <= grant[1] ? REQ1_STRB : REQ0_STRB;
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          aw_valid <= aw_hold;
          w_valid  <= w_hold;
          if (!aw_hold && !w_hold) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (AXI_BVALID) begin
            done0_q <= (owner == 1'b0);
            done1_q <= (owner == 1'b1);
            bresp_q <= AXI_BRESP;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // W-channel stall watchdog
  // --------------------------------------------------------------------------
  // The counter holds the number of completed stall cycles; the flag is
  // registered on the same edge that moves the counter to MAXWAIT+1, so the
  // pulse is visible exactly while the counter first reads MAXWAIT+1.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!w_hold) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_W'(CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == CNT_W'(CNT_MAX - 1)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign AXI_AWADDR  = addr_q;
  assign AXI_AWVALID = aw_valid;
  assign AXI_WDATA   = data_q;
  assign AXI_WSTRB   = strb_q;
  assign AXI_WVALID  = w_valid;
  assign AXI_BREADY  = (state == RESP);

  assign REQ0_DONE  = done0_q;
  assign REQ1_DONE  = done1_q;
  assign REQ0_BRESP = done0_q ? bresp_q : BRESP_OKAY;
  assign REQ1_BRESP = done1_q ? bresp_q : BRESP_OKAY;

  assign ERR_TIMEOUT = err_q;

endmodule

// File: doc/axil_wr_arbiter.md
AXIL_WR_ARBITER -- requirements
Module: axil_wr_arbiter

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, meaning the data width of WDATA and requester data.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 8, meaning the width of AWADDR and requester address.
REQ-003 SHALL have parameter MAXWAIT, default 5, meaning the number of WREADY wait cycles tolerated before a timeout flag.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 AXI_ACLK  in  1  clock; all state changes on its rising edge.
REQ-006 AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-007 REQn_VALID  in  1  requester n (n=0,1) has a pending write.
REQ-008 REQn_READY  out  1  single-cycle pulse: requester n's payload is captured this cycle.
REQ-009 REQn_ADDR / REQn_DATA / REQn_STRB  in  ADDR_W / DATA_W / DATA_W/8  requester n's write payload.
REQ-010 REQn_DONE  out  1  single-cycle pulse: requester n's write completed.
REQ-011 REQn_BRESP  out  2  BRESP of the completed write; valid while REQn_DONE=1.
REQ-012 AXI_AWADDR/AWVALID/AWREADY  out/out/in  ADDR_W/1/1  AXI-Lite write-address channel.
REQ-013 AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_W/DATA_W/8/1/1  AXI-Lite write-data channel.
REQ-014 AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  AXI-Lite write-response channel.
REQ-015 ERR_TIMEOUT  out  1  single-cycle pulse when WREADY wait exceeds MAXWAIT.

Function
REQ-016 SHALL use the FSM states IDLE, XFER and RESP.
REQ-017 IDLE: if any REQn_VALID, assert the granted REQn_READY combinationally, register that requester's payload and ID at the edge, and go to XFER.
REQ-018 Arbitration SHALL be two-way round robin: a lone requester wins; on simultaneous requests the requester not granted last wins; after reset req0 has priority.
REQ-019 XFER: AWVALID and WVALID SHALL assert together starting the cycle after the grant.
REQ-020 Each VALID SHALL deassert independently on the cycle after its handshake (VALID&READY), with AW and W accepted in either order or together.
REQ-021 Move from XFER to RESP when both AW and W handshakes have occurred; a same-cycle double handshake moves to RESP in one cycle.
REQ-022 While VALID=1 and READY=0, AWVALID, WVALID, AWADDR, WDATA and WSTRB SHALL stay stable; VALID is never withdrawn before handshake.
REQ-023 RESP: BREADY=1; on BVALID, pulse REQn_DONE for the owning requester with REQn_BRESP=AXI_BRESP, then return to IDLE.
REQ-024 Grant-to-DONE minimum latency SHALL be 3 cycles (grant, AW/W handshake, B handshake).
REQ-025 Wait counter SHALL count consecutive cycles with WVALID=1 and WREADY=0, saturate at MAXWAIT+1, and clear on W handshake.
REQ-026 ERR_TIMEOUT SHALL pulse once when the counter reaches MAXWAIT+1; WVALID stays asserted (no abort).
REQ-027 REQn_READY SHALL not assert outside IDLE; at most one REQn_READY and one REQn_DONE may be high in any cycle.
REQ-028 A requester dropping REQn_VALID before grant SHALL be ignored; no payload is captured.

Reset
REQ-029 While AXI_ARESET=1: state=IDLE, all VALID/READY/DONE outputs=0, ERR_TIMEOUT=0, wait counter=0, and round-robin pointer favours req0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no DONE pulse; AWVALID/WVALID SHALL be 0 on the first cycle after reset release.
REQ-031 Data/address registers need not be reset, but AXI_WDATA SHALL never be X while WVALID=1.

Structure
REQ-032 Package axil_wr_pkg SHALL hold the state enum, BRESP codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and requester-ID type.
REQ-033 Round-robin grant logic SHALL be a sub-module axil_rr_arb2 (inputs: req[1:0], advance; output: one-hot grant[1:0]).
REQ-034 The block SHALL pass all assertions of the team's AXI-Lite write-data checker when bound to its W channel.

Verification
REQ-035 Scenario: REQ0 only, ADDR=0x10, DATA=0xDEADBEEF, STRB=0xF, slave ready immediately, BRESP=0 -> REQ0_DONE 3 cycles after grant with BRESP=0.
REQ-036 Scenario: REQ0 and REQ1 both valid in the same cycle, two times -> grants go to 0, then 1, then 0.
REQ-037 Scenario: AWREADY 2 cycles before WREADY, WREADY held low 3 cycles -> WDATA stable throughout, single RESP entry, no ERR_TIMEOUT.
REQ-038 Scenario: WREADY held low 8 cycles with MAXWAIT=5 -> exactly one ERR_TIMEOUT pulse at wait cycle 6, WVALID held, then completion.
REQ-039 Scenario: AXI_ARESET asserted in RESP -> outputs 0 immediately, no DONE, WVALID=0 the cycle after release, req0 wins the next arbitration.
REQ-040 Scenario: BRESP=2 (SLVERR) for REQ1 write -> REQ1_BRESP=2 with the REQ1_DONE pulse.
